// File: rtl/coef_fetch_seq_if.sv
// coef_fetch_seq_if: start/status, coefficient ROM read port and MAC coefficient stream
interface coef_fetch_seq_if #(
  parameter int DWIDTH = 16,
  parameter int NTAPS = 16,
  parameter int NBANDS = 4
);
  logic start;
  logic [$clog2(NBANDS)-1:0] band;
  logic busy;
  logic done;
  logic err;
  logic rom_rd;
  logic [31:0] rom_addr;
  logic [DWIDTH-1:0] rom_data;
  logic [DWIDTH-1:0] coef;
  logic coef_valid;
  logic coef_ready;
  logic [$clog2(NTAPS)-1:0] tap;
  modport master (
    input start, band, rom_data, coef_ready,
    output busy, done, err, rom_rd, rom_addr, coef, coef_valid, tap
  );
  modport slave (
    output start, band, rom_data, coef_ready,
    input busy, done, err, rom_rd, rom_addr, coef, coef_valid, tap
  );
endinterface

// File: rtl/coef_fetch_seq.sv
// coef_fetch_seq: fetches one band of coefficients from the ROM and streams them over valid/ready
module coef_fetch_seq #(
  parameter int DWIDTH = 16,
  parameter int NTAPS = 16,
  parameter int NBANDS = 4
) (
  input logic clock,
  input logic reset,
  coef_fetch_seq_if.master bus
);
  localparam int AW = $clog2(NTAPS * NBANDS);
  localparam int TW = $clog2(NTAPS);
  localparam int CW = $clog2(NTAPS + 1);
  localparam int BW1 = $clog2(NBANDS) + 1;
  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  logic [CW-1:0] issue_q, issue_d, acc_q, acc_d;
  logic [TW-1:0] tap_q, tap_d;
  logic valid_q, valid_d, err_q, err_d;
  logic start_ok, band_ok, go, accept, last;
  if (NTAPS * NBANDS > 64) begin : g_depth_check
    $error("NTAPS*NBANDS exceeds the 64-word coefficient ROM");
  end
  always_comb begin
    start_ok = state_q == IDLE && bus.start;
    band_ok = {1'b0, bus.band} < BW1'(NBANDS);
    go = start_ok && band_ok;
    accept = valid_q && bus.coef_ready;
    last = accept && acc_q == CW'(NTAPS - 1);
    bus.rom_rd = state_q == FETCH && issue_q < CW'(NTAPS) && (!valid_q || bus.coef_ready);
    bus.rom_addr = 32'(base_q + AW'(issue_q));
    err_d = start_ok && !band_ok;
    state_d = go ? FETCH : last ? DONE : state_q == DONE ? IDLE : state_q;
    base_d = go ? AW'(bus.band) * AW'(NTAPS) : base_q;
    issue_d = go ? '0 : bus.rom_rd ? issue_q + CW'(1) : issue_q;
    acc_d = go ? '0 : accept ? acc_q + CW'(1) : acc_q;
    valid_d = bus.rom_rd ? 1'b1 : bus.coef_ready ? 1'b0 : valid_q;
    tap_d = bus.rom_rd ? TW'(issue_q) : tap_q;
    bus.busy = state_q == FETCH;
    bus.done = state_q == DONE;
    bus.err = err_q;
    bus.coef = bus.rom_data;
    bus.coef_valid = valid_q;
    bus.tap = tap_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      base_q <= '0;
      issue_q <= '0;
      acc_q <= '0;
      tap_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      issue_q <= issue_d;
      acc_q <= acc_d;
      tap_q <= tap_d;
      valid_q <= valid_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_coef_fetch_seq.sv
// tb_coef_fetch_seq: scoreboard bench with a queue-based band/tap model and a ROM model
module tb_coef_fetch_seq;
  localparam int DW = 16;
  localparam int NT = 16;
  localparam int NB = 3;
  logic clock = 1'b0;
  logic reset = 1'b1;
  coef_fetch_seq_if #(.DWIDTH(DW), .NTAPS(NT), .NBANDS(NB)) bus ();
  coef_fetch_seq #(.DWIDTH(DW), .NTAPS(NT), .NBANDS(NB)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.master)
  );
  always #5 clock = ~clock;
  logic [DW-1:0] rom [64];
  always @(posedge clock) if (bus.rom_rd) bus.rom_data <= rom[bus.rom_addr[5:0]];
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;
  int total = 0, passed = 0;
  logic [63:0] exp_q[$];
  int addr_q[$];
  int done_iss = 0, done_seen = 0, err_iss = 0, err_seen = 0;
  int mode = 0, t0 = 0, first_rd = -1, first_hs = -1, last_hs = -1, done_cyc = -1;
  logic hit;
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask
  task automatic check_quiet(input string name);
    check(name, {bus.rom_addr, 16'(bus.tap), 11'd0, bus.busy, bus.done, bus.err, bus.rom_rd, bus.coef_valid}, 64'd0);
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    bus.coef_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 9) < 7) : !(cyc - t0 >= 5 && cyc - t0 <= 8);
  endtask
  task automatic issue(input int b);
    bus.start = 1'b1;
    bus.band = 2'(b);
    if (done_iss == done_seen) begin
      if (b < NB) begin
        for (int k = 0; k < NT; k++) begin
          exp_q.push_back({32'(k), 32'(rom[b * NT + k])});
          addr_q.push_back(b * NT + k);
        end
        done_iss++;
      end else err_iss++;
    end
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((done_iss != done_seen || err_iss != err_seen) && n < 400) begin
      tick();
      n++;
    end
    check("drain", {32'(done_iss - done_seen), 32'(err_iss - err_seen)}, 64'd0);
    tick();
  endtask
  task automatic run_timed(input int b);
    tick();
    t0 = cyc;
    bus.coef_ready = 1'b1;
    first_rd = -1;
    first_hs = -1;
    last_hs = -1;
    done_cyc = -1;
    issue(b);
    wait_idle();
  endtask
  initial begin
    logic stall = 1'b0;
    logic [63:0] prev = '0, cur;
    forever begin
      @(negedge clock);
      cur = {32'(bus.tap), 15'd0, bus.coef_valid, 16'(bus.coef)};
      if (reset) begin
        exp_q.delete();
        addr_q.delete();
        done_seen = done_iss;
        err_seen = err_iss;
        stall = 1'b0;
      end else begin
        if (stall) check("hold", cur, prev);
        if (bus.rom_rd) begin
          if (first_rd < 0) first_rd = cyc;
          check("addr_expected", 64'(addr_q.size() != 0), 64'd1);
          if (addr_q.size() != 0) check("rom_addr", 64'(bus.rom_addr), 64'(addr_q.pop_front()));
        end
        if (bus.coef_valid && bus.coef_ready) begin
          if (first_hs < 0) first_hs = cyc;
          last_hs = cyc;
          check("coef_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) check("tap_coef", {32'(bus.tap), 32'(bus.coef)}, exp_q.pop_front());
        end
        if (bus.coef_valid && !bus.coef_ready) check("stall_rom_rd", 64'(bus.rom_rd), 64'd0);
        if (bus.done) begin
          done_cyc = cyc;
          check("done_expected", {62'd0, done_iss > done_seen, exp_q.size() == 0}, 64'd3);
          done_seen++;
        end
        if (bus.err) begin
          check("err_expected", 64'(err_iss > err_seen), 64'd1);
          err_seen++;
        end
        stall = bus.coef_valid && !bus.coef_ready;
        prev = cur;
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < 64; i++) rom[i] = DW'($urandom);
    bus.start = 1'b0;
    bus.band = '0;
    bus.coef_ready = 1'b0;
    repeat (3) tick();
    @(negedge clock);
    check_quiet("reset_state");
    reset = 1'b0;
    tick();
    @(negedge clock);
    check_quiet("post_reset");
    run_timed(0);
    check("first_rd_lat", 64'(first_rd - t0), 64'd1);
    check("first_coef_lat", 64'(first_hs - t0), 64'd2);
    check("last_coef_lat", 64'(last_hs - t0), 64'(NT + 1));
    check("done_lat", 64'(done_cyc - t0), 64'(NT + 2));
    run_timed(2);
    check("band2_done_lat", 64'(done_cyc - t0), 64'(NT + 2));
    mode = 2;
    run_timed(1);
    check("stall_done_lat", 64'(done_cyc - t0), 64'(NT + 6));
    mode = 0;
    tick();
    issue(NB);
    tick();
    @(negedge clock);
    check("err_quiet1", {61'd0, bus.busy, bus.rom_rd, bus.coef_valid}, 64'd0);
    tick();
    @(negedge clock);
    check("err_quiet2", {61'd0, bus.busy, bus.rom_rd, bus.coef_valid}, 64'd0);
    wait_idle();
    tick();
    issue(0);
    repeat (3) tick();
    issue(1);
    wait_idle();
    tick();
    t0 = cyc;
    issue(2);
    while (cyc < t0 + NT + 2) tick();
    issue(1);
    tick();
    issue(0);
    wait_idle();
    tick();
    t0 = cyc;
    issue(1);
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clock);
      hit = bus.coef_valid && bus.tap == 4'd7;
    end
    check("tap7_seen", 64'(hit), 64'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    check_quiet("abort_state");
    run_timed(0);
    check("restart_lat", 64'(first_hs - t0), 64'd2);
    mode = 1;
    for (int n = 0; n < 14; n++) begin
      tick();
      issue($urandom_range(0, NB));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 6)) tick();
        issue($urandom_range(0, NB));
      end
      wait_idle();
    end
    mode = 0;
    repeat (4) tick();
    check("queues_empty", 64'(exp_q.size() + addr_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
